ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit on the execute side of the ID/EX pipeline register. It consumes the latched operands and the M-extension opcode, computes the result over a fixed number of cycles, and drives `hold` back into the ID/EX and earlier pipeline registers so the instruction stays parked until the result is ready. It is the consumer and stall-source counterpart of the ID/EX register's `hold` input.

---
 rtl/ex_muldiv.sv | 152 +++++++++++++++
 tb/tb_ex_muldiv.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit with pipeline stall request
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_rdata_i,
    input  logic [XLEN-1:0] rs2_rdata_i,
    input  logic [4:0]      rd_waddr_i,
    input  logic            flush_i,
    output logic            hold_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_waddr_o,
    output logic            result_valid_o,
    output logic            busy_o
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nx;
    logic              start;
    logic [4:0]        cnt;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              sa_q, sb_q;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     rem;
    logic [XLEN-1:0]   quo;

    // Operand signedness and magnitudes for the instruction being accepted
    logic            signed_a, signed_b, sa_in, sb_in, div_zero, div_ovf, special;
    logic [XLEN-1:0] a_mag_in, b_mag_in, special_res;

    always_comb begin
        signed_a = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
        signed_b = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
        sa_in    = signed_a & rs1_rdata_i[XLEN-1];
        sb_in    = signed_b & rs2_rdata_i[XLEN-1];
        a_mag_in = sa_in ? -rs1_rdata_i : rs1_rdata_i;
        b_mag_in = sb_in ? -rs2_rdata_i : rs2_rdata_i;
        div_zero = op_i[2] && (rs2_rdata_i == '0);
        div_ovf  = ((op_i == 3'b100) || (op_i == 3'b110)) &&
                   (rs1_rdata_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_rdata_i == '1);
        special  = div_zero | div_ovf;
        if (div_zero)
            special_res = op_i[1] ? rs1_rdata_i : '1;
        else
            special_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One shift-add step and one restoring shift-subtract step per cycle
    logic [XLEN:0]     mul_sum, div_sh, rem_nx;
    logic [2*XLEN-1:0] prod_nx, prod_sgn;
    logic [XLEN-1:0]   quo_nx, quo_sgn, rem_sgn, calc_res;
    logic              div_ge;

    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_mag} : '0);
        prod_nx  = {mul_sum, prod[XLEN-1:1]};
        div_sh   = {rem[XLEN-1:0], quo[XLEN-1]};
        // rem[XLEN] is the bit shifted out; if set the shifted value exceeds any divisor
        div_ge   = rem[XLEN] || (div_sh >= {1'b0, b_mag});
        rem_nx   = div_ge ? (div_sh - {1'b0, b_mag}) : div_sh;
        quo_nx   = {quo[XLEN-2:0], div_ge};
        prod_sgn = (sa_q ^ sb_q) ? -prod_nx : prod_nx;
        quo_sgn  = (sa_q ^ sb_q) ? -quo_nx : quo_nx;
        rem_sgn  = sa_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
        if (!op_q[2])
            calc_res = (op_q[1:0] == 2'b00) ? prod_sgn[XLEN-1:0] : prod_sgn[2*XLEN-1:XLEN];
        else
            calc_res = op_q[1] ? rem_sgn : quo_sgn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        hold_o   = 1'b0;
        start    = 1'b0;
        case (state)
            IDLE: begin
                hold_o = valid_i;
                start  = valid_i;
                if (valid_i)
                    state_nx = special ? DONE : CALC;
            end
            CALC: begin
                hold_o = 1'b1;
                if (cnt == 5'd31)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush_i) begin
            state_nx = IDLE;
            hold_o   = 1'b0;
            start    = 1'b0;
        end
    end

    assign result_valid_o = (state == DONE) && !flush_i;
    assign busy_o         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            a_mag      <= '0;
            b_mag      <= '0;
            prod       <= '0;
            rem        <= '0;
            quo        <= '0;
            result_o   <= '0;
            rd_waddr_o <= '0;
        end else if (start) begin
            cnt   <= '0;
            op_q  <= op_i;
            rd_q  <= rd_waddr_i;
            sa_q  <= sa_in;
            sb_q  <= sb_in;
            a_mag <= a_mag_in;
            b_mag <= b_mag_in;
            prod  <= {{XLEN{1'b0}}, b_mag_in};
            rem   <= '0;
            quo   <= a_mag_in;
            if (special) begin
                result_o   <= special_res;
                rd_waddr_o <= rd_waddr_i;
            end
        end else if (state == CALC) begin
            cnt  <= cnt + 5'd1;
            prod <= prod_nx;
            rem  <= rem_nx;
            quo  <= quo_nx;
            if (cnt == 5'd31 && !flush_i) begin
                result_o   <= calc_res;
                rd_waddr_o <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_rdata_i, rs2_rdata_i;
    logic [4:0]  rd_waddr_i;
    logic        flush_i;
    logic        hold_o;
    logic [31:0] result_o;
    logic [4:0]  rd_waddr_o;
    logic        result_valid_o;
    logic        busy_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i),
        .rs1_rdata_i(rs1_rdata_i), .rs2_rdata_i(rs2_rdata_i), .rd_waddr_i(rd_waddr_i),
        .flush_i(flush_i), .hold_o(hold_o), .result_o(result_o), .rd_waddr_o(rd_waddr_o),
        .result_valid_o(result_valid_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drives one instruction from a negedge, reports when/what completed; returns at the negedge after DONE
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int done_cyc, output logic [31:0] res,
                          output logic [4:0] rdo, output int hold_cnt, output int last_hold);
        valid_i = 1'b1; op_i = op; rs1_rdata_i = a; rs2_rdata_i = b; rd_waddr_i = rd;
        done_cyc = -1; hold_cnt = 0; last_hold = -1; res = '0; rdo = '0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (hold_o) begin hold_cnt++; last_hold = c; end
            if (result_valid_o) begin done_cyc = c; res = result_o; rdo = rd_waddr_o; end
            @(negedge clk);
            if (c == 0) begin rs1_rdata_i = $urandom; rs2_rdata_i = $urandom; end
            if (done_cyc >= 0) break;
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (result_o !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h expected %h", result_o, 32'h0); end
        vectors++; if (rd_waddr_o !== 5'h0) begin miscompares++; $display("FAIL reset_rd: got %h expected %h", rd_waddr_o, 5'h0); end
        vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", result_valid_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        vectors++; if (hold_o !== 1'b0) begin miscompares++; $display("FAIL reset_hold: got %b expected 0", hold_o); end
        @(negedge clk);
    endtask

    task automatic test_mul_timing();
        int d, hc, lh; logic [31:0] r; logic [4:0] rdo;
        run_op(MUL, 32'd7, 32'hFFFFFFFD, 5'd5, d, r, rdo, hc, lh);
        vectors++; if (d !== 33) begin miscompares++; $display("FAIL mul_done_cycle: got %0d expected 33", d); end
        vectors++; if (r !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mul_result: got %h expected FFFFFFEB", r); end
        vectors++; if (rdo !== 5'd5) begin miscompares++; $display("FAIL mul_rd: got %0d expected 5", rdo); end
        vectors++; if (hc !== 33) begin miscompares++; $display("FAIL mul_hold_count: got %0d expected 33", hc); end
        vectors++; if (lh !== 32) begin miscompares++; $display("FAIL mul_hold_last: got %0d expected 32", lh); end
    endtask

    logic [2:0]  t_op [12] = '{MULH, MULHU, MULHSU, MULHU, MULH, MUL, DIV, REM, DIVU, REMU, DIV, REM};
    logic [31:0] t_a  [12] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd100, 32'hFFFFFF9C};
    logic [31:0] t_b  [12] = '{32'h80000000, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000,
                               32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFF9, 32'd7};
    logic [31:0] t_exp[12] = '{32'h40000000, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000, 32'h00000000,
                               32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFF2, 32'hFFFFFFFE};

    task automatic test_arith();
        int d, hc, lh; logic [31:0] r; logic [4:0] rdo;
        for (int i = 0; i < 12; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 5'(i + 1), d, r, rdo, hc, lh);
            vectors++;
            if (r !== t_exp[i] || d !== 33 || rdo !== 5'(i + 1)) begin
                miscompares++;
                $display("FAIL arith[%0d] op=%0d: got %h at cycle %0d rd %0d expected %h at cycle 33 rd %0d",
                         i, t_op[i], r, d, rdo, t_exp[i], i + 1);
            end
        end
    endtask

    logic [2:0]  s_op [4] = '{DIVU, REM, DIV, REM};
    logic [31:0] s_a  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] s_b  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] s_exp[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};

    task automatic test_special();
        int d, hc, lh; logic [31:0] r; logic [4:0] rdo;
        for (int i = 0; i < 4; i++) begin
            run_op(s_op[i], s_a[i], s_b[i], 5'(20 + i), d, r, rdo, hc, lh);
            vectors++;
            if (r !== s_exp[i] || d !== 1 || hc !== 1 || rdo !== 5'(20 + i)) begin
                miscompares++;
                $display("FAIL special[%0d]: got %h cycle %0d holds %0d rd %0d expected %h cycle 1 holds 1 rd %0d",
                         i, r, d, hc, rdo, s_exp[i], 20 + i);
            end
        end
    endtask

    task automatic test_flush();
        int d, hc, lh, seen; logic [31:0] r; logic [4:0] rdo;
        valid_i = 1'b1; flush_i = 1'b1; op_i = MUL; rs1_rdata_i = 32'd9; rs2_rdata_i = 32'd9; rd_waddr_i = 5'd3;
        #1;
        vectors++; if (hold_o !== 1'b0) begin miscompares++; $display("FAIL flush_idle_hold: got %b expected 0", hold_o); end
        @(negedge clk); flush_i = 1'b0; valid_i = 1'b0; #1;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL flush_idle_busy: got %b expected 0", busy_o); end
        @(negedge clk);
        valid_i = 1'b1; op_i = DIV; rs1_rdata_i = 32'd1000; rs2_rdata_i = 32'd3; rd_waddr_i = 5'd7;
        repeat (10) @(negedge clk);
        flush_i = 1'b1; #1;
        vectors++; if (hold_o !== 1'b0 || result_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL flush_calc_hold: got hold %b valid %b expected 0 0", hold_o, result_valid_o); end
        @(negedge clk); flush_i = 1'b0; valid_i = 1'b0; #1;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL flush_calc_idle: got busy %b expected 0", busy_o); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin @(negedge clk); #1; if (result_valid_o) seen++; end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL flush_no_pulse: got %0d pulses expected 0", seen); end
        @(negedge clk);
        run_op(MUL, 32'h00012345, 32'h00000100, 5'd11, d, r, rdo, hc, lh);
        vectors++; if (r !== 32'h01234500 || d !== 33 || rdo !== 5'd11) begin
            miscompares++; $display("FAIL flush_then_mul: got %h cycle %0d rd %0d expected 01234500 cycle 33 rd 11", r, d, rdo); end
    endtask

    task automatic test_async_reset();
        int d, hc, lh, seen; logic [31:0] r; logic [4:0] rdo;
        valid_i = 1'b1; op_i = MUL; rs1_rdata_i = 32'd1234; rs2_rdata_i = 32'd5678; rd_waddr_i = 5'd13;
        repeat (20) @(negedge clk);
        rst = 1'b1; valid_i = 1'b0; #1;
        vectors++; if (result_o !== 32'h0 || rd_waddr_o !== 5'h0) begin
            miscompares++; $display("FAIL rst_mid_outputs: got %h rd %0d expected 0 rd 0", result_o, rd_waddr_o); end
        vectors++; if (busy_o !== 1'b0 || result_valid_o !== 1'b0 || hold_o !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_status: got busy %b valid %b hold %b expected 0 0 0", busy_o, result_valid_o, hold_o); end
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin #1; if (result_valid_o || busy_o) seen++; @(negedge clk); end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rst_nothing_pending: got %0d active cycles expected 0", seen); end
        run_op(MUL, 32'd3, 32'd4, 5'd9, d, r, rdo, hc, lh);
        vectors++; if (r !== 32'd12 || d !== 33 || rdo !== 5'd9) begin
            miscompares++; $display("FAIL rst_then_mul: got %0d cycle %0d rd %0d expected 12 cycle 33 rd 9", r, d, rdo); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, hc, lh, c1, c2; logic [31:0] r1, r2; logic [4:0] rdo;
        c1 = cyc;
        run_op(DIVU, 32'd1000, 32'd10, 5'd1, d1, r1, rdo, hc, lh);
        c2 = cyc;
        run_op(MULHU, 32'hFFFFFFFF, 32'h00000010, 5'd2, d2, r2, rdo, hc, lh);
        vectors++; if (r1 !== 32'd100 || d1 !== 33) begin
            miscompares++; $display("FAIL b2b_first: got %0d cycle %0d expected 100 cycle 33", r1, d1); end
        vectors++; if (r2 !== 32'h0000000F || d2 !== 33) begin
            miscompares++; $display("FAIL b2b_second: got %h cycle %0d expected 0000000F cycle 33", r2, d2); end
        vectors++; if (c2 - c1 !== 34) begin
            miscompares++; $display("FAIL b2b_spacing: got %0d cycles expected 34", c2 - c1); end
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; op_i = '0;
        rs1_rdata_i = '0; rs2_rdata_i = '0; rd_waddr_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_mul_timing();
        test_arith();
        test_special();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
